// File: rtl/gcd_pkg.sv
// Shared constants and types for the binary GCD engine.
package gcd_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 12;

  localparam logic [2:0] OP_GCD     = 3'b000;
  localparam logic [2:0] OP_COPRIME = 3'b001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_step.sv
// One Stein iteration: reduces (a, b, k) by a single rule, or holds once either operand is zero.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int K_W   = $clog2(DEF_WIDTH) + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next,
  output logic [K_W-1:0]   k_next,
  output logic             converged
);

  localparam logic [K_W-1:0] K_ONE = {{(K_W-1){1'b0}}, 1'b1};

  // Priority-ordered step rules; holding once converged keeps k from running away on a zero operand.
  always_comb begin
    converged = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
    a_next    = a;
    b_next    = b;
    k_next    = k;
    if (converged) begin
      a_next = a;
      b_next = b;
      k_next = k;
    end else if (!a[0] && !b[0]) begin
      a_next = a >> 1;
      b_next = b >> 1;
      k_next = k + K_ONE;
    end else if (!a[0]) begin
      a_next = a >> 1;
    end else if (!b[0]) begin
      b_next = b >> 1;
    end else if (a >= b) begin
      a_next = (a - b) >> 1;
    end else begin
      b_next = (b - a) >> 1;
    end
  end

endmodule

// File: rtl/gcd_core.sv
// Binary GCD engine: FSM, iteration counter and registered result, with an optional constant-time mode.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START_PULSE,
  input  logic [2:0]       OPCODE,
  input  logic             CONSTANT_TIME,
  input  logic [CNT_W-1:0] CYCLE_COUNT,
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
  output logic [WIDTH-1:0] RESULT,
  output logic             ERR,
  output logic [CNT_W-1:0] CYCLES_USED,
  output logic             BUSY,
  output logic             DONE_PULSE
);

  localparam int K_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] a_r, b_r, a_nx_s, b_nx_s, step_a_s, step_b_s, g_s;
  logic [K_W-1:0]   k_r, k_nx_s, step_k_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s, cnt_inc_s, budget_r, budget_nx_s;
  logic [2:0]       opcode_r, opcode_nx_s;
  logic             ct_r, ct_nx_s, conv_s, illegal_s, fin_conv_s;
  logic [WIDTH-1:0] result_nx_s;
  logic [CNT_W-1:0] cycles_nx_s;
  logic             err_nx_s, busy_nx_s, done_nx_s;

  gcd_step #(.WIDTH(WIDTH), .K_W(K_W)) u_step (
    .a         (a_r),
    .b         (b_r),
    .k         (k_r),
    .a_next    (step_a_s),
    .b_next    (step_b_s),
    .k_next    (step_k_s),
    .converged (conv_s)
  );

  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_ONE;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decision; constant-time runs ignore convergence and stop only on the budget.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (START_PULSE) begin
          if ((OPCODE != OP_GCD) && (OPCODE != OP_COPRIME)) begin
            state_nx_s = FINISH;
          end else if (CONSTANT_TIME && (CYCLE_COUNT == {CNT_W{1'b0}})) begin
            state_nx_s = FINISH;
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (ct_r) begin
          state_nx_s = (cnt_inc_s == budget_r) ? FINISH : RUN;
        end else begin
          state_nx_s = conv_s ? FINISH : RUN;
        end
      end
      FINISH:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Next datapath and output values; results are judged on the values FINISH will hold.
  always_comb begin
    a_nx_s      = a_r;
    b_nx_s      = b_r;
    k_nx_s      = k_r;
    cnt_nx_s    = cnt_r;
    opcode_nx_s = opcode_r;
    ct_nx_s     = ct_r;
    budget_nx_s = budget_r;
    result_nx_s = RESULT;
    err_nx_s    = ERR;
    cycles_nx_s = CYCLES_USED;
    busy_nx_s   = (state_nx_s != IDLE);
    done_nx_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (START_PULSE) begin
          a_nx_s      = OPA;
          b_nx_s      = OPB;
          k_nx_s      = {K_W{1'b0}};
          cnt_nx_s    = {CNT_W{1'b0}};
          opcode_nx_s = OPCODE;
          ct_nx_s     = CONSTANT_TIME;
          budget_nx_s = CYCLE_COUNT;
          err_nx_s    = 1'b0;
        end else begin
          err_nx_s = ERR;
        end
      end
      RUN: begin
        a_nx_s   = step_a_s;
        b_nx_s   = step_b_s;
        k_nx_s   = step_k_s;
        cnt_nx_s = cnt_inc_s;
      end
      FINISH:  cnt_nx_s = cnt_r;
      default: cnt_nx_s = cnt_r;
    endcase

    g_s        = (a_nx_s | b_nx_s) << k_nx_s;
    fin_conv_s = (a_nx_s == {WIDTH{1'b0}}) || (b_nx_s == {WIDTH{1'b0}});
    illegal_s  = (opcode_nx_s != OP_GCD) && (opcode_nx_s != OP_COPRIME);
    if (state_nx_s == FINISH) begin
      done_nx_s   = 1'b1;
      cycles_nx_s = cnt_nx_s;
      if (illegal_s || !fin_conv_s) begin
        err_nx_s    = 1'b1;
        result_nx_s = {WIDTH{1'b0}};
      end else begin
        err_nx_s    = 1'b0;
        result_nx_s = (opcode_nx_s == OP_COPRIME) ?
                      {{(WIDTH-1){1'b0}}, (g_s == W_ONE)} : g_s;
      end
    end else begin
      done_nx_s = 1'b0;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      k_r         <= {K_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      opcode_r    <= 3'b000;
      ct_r        <= 1'b0;
      budget_r    <= {CNT_W{1'b0}};
      RESULT      <= {WIDTH{1'b0}};
      ERR         <= 1'b0;
      CYCLES_USED <= {CNT_W{1'b0}};
      BUSY        <= 1'b0;
      DONE_PULSE  <= 1'b0;
    end else begin
      a_r         <= a_nx_s;
      b_r         <= b_nx_s;
      k_r         <= k_nx_s;
      cnt_r       <= cnt_nx_s;
      opcode_r    <= opcode_nx_s;
      ct_r        <= ct_nx_s;
      budget_r    <= budget_nx_s;
      RESULT      <= result_nx_s;
      ERR         <= err_nx_s;
      CYCLES_USED <= cycles_nx_s;
      BUSY        <= busy_nx_s;
      DONE_PULSE  <= done_nx_s;
    end
  end

endmodule

// File: tb/tb_gcd_core.sv
// Self-checking bench for gcd_core: directed vectors, randomized operations against a reference model, and control corner cases.
module tb_gcd_core;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START_PULSE = 1'b0;
  logic [2:0]  OPCODE = 3'b000;
  logic        CONSTANT_TIME = 1'b0;
  logic [11:0] CYCLE_COUNT = 12'd0;
  logic [31:0] OPA = 32'd0;
  logic [31:0] OPB = 32'd0;
  logic [31:0] RESULT;
  logic        ERR;
  logic [11:0] CYCLES_USED;
  logic        BUSY;
  logic        DONE_PULSE;

  int cmp_cnt = 0;
  int err_cnt = 0;

  gcd_core dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .START_PULSE   (START_PULSE),
    .OPCODE        (OPCODE),
    .CONSTANT_TIME (CONSTANT_TIME),
    .CYCLE_COUNT   (CYCLE_COUNT),
    .OPA           (OPA),
    .OPB           (OPB),
    .RESULT        (RESULT),
    .ERR           (ERR),
    .CYCLES_USED   (CYCLES_USED),
    .BUSY          (BUSY),
    .DONE_PULSE    (DONE_PULSE)
  );

  always #5 CLK = ~CLK;

  // Reference: Euclid's algorithm for the true GCD.
  function automatic logic [31:0] ref_gcd(input logic [31:0] a0, input logic [31:0] b0);
    logic [31:0] a = a0, b = b0, t;
    while (b != 32'd0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Reference: number of binary-GCD iterations until one operand reaches zero.
  function automatic int ref_steps(input logic [31:0] a0, input logic [31:0] b0);
    logic [31:0] a = a0, b = b0;
    int n = 0;
    while (a != 32'd0 && b != 32'd0) begin
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a >= b) a = (a - b) / 2;
      else b = (b - a) / 2;
      n++;
    end
    return n;
  endfunction

  task automatic do_op(input logic [2:0] op, input logic ct, input logic [11:0] cc,
                       input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic err,
                       output logic [11:0] cyc, output logic busy_d, output logic quiet_after);
    @(negedge CLK);
    OPCODE = op; CONSTANT_TIME = ct; CYCLE_COUNT = cc; OPA = a; OPB = b;
    START_PULSE = 1'b1;
    @(posedge CLK);
    #1 START_PULSE = 1'b0;
    lat = -1; res = 32'd0; err = 1'b0; cyc = 12'd0; busy_d = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge CLK);
      if (DONE_PULSE) begin
        lat = n; res = RESULT; err = ERR; cyc = CYCLES_USED; busy_d = BUSY;
        break;
      end
    end
    @(negedge CLK);
    quiet_after = !DONE_PULSE && !BUSY;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    cmp_cnt++;
    if ({RESULT, ERR, CYCLES_USED, BUSY, DONE_PULSE} !== 47'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got res=%0d err=%0b cyc=%0d busy=%0b done=%0b, want all 0",
               RESULT, ERR, CYCLES_USED, BUSY, DONE_PULSE);
    end
    RESET = 1'b0;
    @(negedge CLK);
    cmp_cnt++;
    if (BUSY !== 1'b0 || DONE_PULSE !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_after_reset: busy=%0b done=%0b, want 0 0", BUSY, DONE_PULSE);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        ct;
    logic [11:0] cc;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    logic        err;
    logic [11:0] cyc;
  } vec_t;

  task automatic test_directed();
    vec_t v[9];
    int lat; logic [31:0] res; logic err, busy_d, quiet; logic [11:0] cyc;
    v[0] = '{3'b000, 1'b0, 12'd0,  32'd48, 32'd18, 8,  32'd6,  1'b0, 12'd7};
    v[1] = '{3'b000, 1'b1, 12'd10, 32'd48, 32'd18, 11, 32'd6,  1'b0, 12'd10};
    v[2] = '{3'b000, 1'b1, 12'd4,  32'd48, 32'd18, 5,  32'd0,  1'b1, 12'd4};
    v[3] = '{3'b000, 1'b1, 12'd6,  32'd48, 32'd18, 7,  32'd6,  1'b0, 12'd6};
    v[4] = '{3'b001, 1'b0, 12'd0,  32'd35, 32'd64, 14, 32'd1,  1'b0, 12'd13};
    v[5] = '{3'b000, 1'b0, 12'd0,  32'd0,  32'd0,  2,  32'd0,  1'b0, 12'd1};
    v[6] = '{3'b000, 1'b1, 12'd0,  32'd0,  32'd77, 1,  32'd77, 1'b0, 12'd0};
    v[7] = '{3'b101, 1'b0, 12'd0,  32'd48, 32'd18, 1,  32'd0,  1'b1, 12'd0};
    v[8] = '{3'b101, 1'b1, 12'd20, 32'd48, 32'd18, 1,  32'd0,  1'b1, 12'd0};
    for (int i = 0; i < 9; i++) begin
      do_op(v[i].op, v[i].ct, v[i].cc, v[i].a, v[i].b, lat, res, err, cyc, busy_d, quiet);
      cmp_cnt++;
      if (lat !== v[i].lat || res !== v[i].res || err !== v[i].err || cyc !== v[i].cyc ||
          busy_d !== 1'b1 || quiet !== 1'b1) begin
        err_cnt++;
        $display("FAIL directed_%0d: got lat=%0d res=%0d err=%0b cyc=%0d busy=%0b quiet=%0b, want lat=%0d res=%0d err=%0b cyc=%0d busy=1 quiet=1",
                 i, lat, res, err, cyc, busy_d, quiet, v[i].lat, v[i].res, v[i].err, v[i].cyc);
      end
    end
  endtask

  task automatic test_random();
    int lat, steps, e_lat; logic [31:0] res, a, b, g, e_res, m;
    logic err, busy_d, quiet, ct, illegal, e_err; logic [11:0] cyc, cc, e_cyc; logic [2:0] op;
    int r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0) begin
        a = $urandom(); b = $urandom();
      end else if (r == 1) begin
        m = $urandom_range(1, 4096);
        a = $urandom_range(0, 5000) * m; b = $urandom_range(0, 5000) * m;
      end else begin
        a = $urandom_range(0, 1) ? 32'd0 : $urandom(); b = (a == 32'd0) ? $urandom() : 32'd0;
      end
      r  = $urandom_range(0, 9);
      op = (r < 5) ? 3'b000 : (r < 9) ? 3'b001 : 3'($urandom_range(2, 7));
      ct = 1'($urandom_range(0, 1));
      cc = 12'($urandom_range(0, 90));
      steps   = ref_steps(a, b);
      g       = ref_gcd(a, b);
      illegal = (op > 3'd1);
      e_lat   = illegal ? 1 : ct ? ((cc == 12'd0) ? 1 : int'(cc) + 1) : steps + 2;
      e_cyc   = illegal ? 12'd0 : ct ? cc : 12'(steps + 1);
      e_err   = illegal || (ct && steps > int'(cc));
      e_res   = e_err ? 32'd0 : (op == 3'b001) ? {31'd0, g == 32'd1} : g;
      do_op(op, ct, cc, a, b, lat, res, err, cyc, busy_d, quiet);
      cmp_cnt++;
      if (lat !== e_lat || res !== e_res || err !== e_err || cyc !== e_cyc || quiet !== 1'b1) begin
        err_cnt++;
        $display("FAIL random_%0d op=%0d ct=%0b cc=%0d a=%0d b=%0d: got lat=%0d res=%0d err=%0b cyc=%0d quiet=%0b, want lat=%0d res=%0d err=%0b cyc=%0d quiet=1",
                 i, op, ct, cc, a, b, lat, res, err, cyc, quiet, e_lat, e_res, e_err, e_cyc);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    @(negedge CLK);
    OPCODE = 3'b000; CONSTANT_TIME = 1'b0; OPA = 32'd48; OPB = 32'd18; START_PULSE = 1'b1;
    @(posedge CLK);
    #1 START_PULSE = 1'b0;
    OPCODE = 3'b101; OPA = 32'd5; OPB = 32'd7;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (DONE_PULSE) dones++;
      START_PULSE = (i == 3) || DONE_PULSE;
    end
    START_PULSE = 1'b0;
    cmp_cnt++;
    if (dones !== 1 || RESULT !== 32'd6 || ERR !== 1'b0 || CYCLES_USED !== 12'd7) begin
      err_cnt++;
      $display("FAIL ignored_start: got dones=%0d res=%0d err=%0b cyc=%0d, want dones=1 res=6 err=0 cyc=7",
               dones, RESULT, ERR, CYCLES_USED);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0, lat, steps; logic [31:0] res; logic err, busy_d, quiet; logic [11:0] cyc;
    @(negedge CLK);
    OPCODE = 3'b000; CONSTANT_TIME = 1'b0; OPA = 32'd48; OPB = 32'd18; START_PULSE = 1'b1;
    @(posedge CLK);
    #1 START_PULSE = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    #1;
    cmp_cnt++;
    if ({RESULT, ERR, CYCLES_USED, BUSY, DONE_PULSE} !== 47'd0) begin
      err_cnt++;
      $display("FAIL reset_mid_run: got res=%0d err=%0b cyc=%0d busy=%0b done=%0b, want all 0",
               RESULT, ERR, CYCLES_USED, BUSY, DONE_PULSE);
    end
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (DONE_PULSE || BUSY) dones++;
    end
    cmp_cnt++;
    if (dones !== 0) begin
      err_cnt++;
      $display("FAIL aborted_op_silent: got %0d active cycles, want 0", dones);
    end
    steps = ref_steps(32'd12, 32'd8);
    do_op(3'b000, 1'b0, 12'd0, 32'd12, 32'd8, lat, res, err, cyc, busy_d, quiet);
    cmp_cnt++;
    if (res !== 32'd4 || err !== 1'b0 || lat !== steps + 2 || cyc !== 12'(steps + 1)) begin
      err_cnt++;
      $display("FAIL after_reset_gcd: got res=%0d err=%0b lat=%0d cyc=%0d, want res=4 err=0 lat=%0d cyc=%0d",
               res, err, lat, cyc, steps + 2, steps + 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
